// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: access size codes and the response FIFO entry.
package lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   // Widest cfg_latency the response entry can hold.
   localparam int RESP_LAT_W = 4;

   typedef struct packed {
      logic                  is_wr;
      logic [31:0]           rdata;
      logic [RESP_LAT_W-1:0] cnt;
   } resp_entry_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response FIFO; each valid entry counts its latency down to zero and
// only the head may report ready.
module sram_resp_fifo
   import lsu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  resp_entry_t              push_entry,
   input  logic                     pop,
   output logic                     head_ready,
   output resp_entry_t              head_entry,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   resp_entry_t      ent [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW:0]      cnt_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + PW'(1);
         end
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Push never targets a live slot: the requester is held off while full.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && wr_ptr == PW'(i))
            ent[i] <= push_entry;
         else if (vld[i] && ent[i].cnt != '0)
            ent[i].cnt <= ent[i].cnt - RESP_LAT_W'(1);
      end
   end

   assign head_entry = ent[rd_ptr];
   assign head_ready = vld[rd_ptr] && (ent[rd_ptr].cnt == '0);
   assign full       = (cnt_q == (PW+1)'(DEPTH));
   assign count      = cnt_q;

endmodule

// File: rtl/sram_like_data_responder.sv
// Data-side SRAM-like responder: word-addressed RAM with byte-strobed stores and
// in-order, latency-configurable responses.
module sram_like_data_responder
   import lsu_pkg::*;
#(
   parameter int MEM_AW          = 12,
   parameter int MAX_OUTSTANDING = 4,
   parameter int LAT_W           = 4
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               req,
   input  logic                               wr,
   input  logic [1:0]                         size,
   input  logic [3:0]                         wstrb,
   input  logic [31:0]                        addr,
   input  logic [31:0]                        wdata,
   output logic                               addr_ok,
   output logic                               data_ok,
   output logic [31:0]                        rdata,
   input  logic [LAT_W-1:0]                   cfg_latency,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

   logic [31:0]       mem [0:(1<<MEM_AW)-1];
   logic [MEM_AW-1:0] word_idx;
   logic              accept;
   logic              full;
   logic              head_ready;
   resp_entry_t       push_entry;
   resp_entry_t       head_entry;

   // Size and sub-word address bits are the requester's concern.
   logic unused_bits;
   assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

   assign word_idx = addr[MEM_AW+1:2];
   assign addr_ok  = req & ~full;
   assign accept   = req & addr_ok;

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b])
               mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      push_entry       = '0;
      push_entry.is_wr = wr;
      push_entry.rdata = wr ? 32'd0 : mem[word_idx];
      push_entry.cnt   = RESP_LAT_W'(cfg_latency);
   end

   sram_resp_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (head_ready),
      .head_ready (head_ready),
      .head_entry (head_entry),
      .full       (full),
      .count      (outstanding)
   );

   assign data_ok = head_ready;
   assign rdata   = (head_ready && !head_entry.is_wr) ? head_entry.rdata : 32'd0;

endmodule

// File: tb/tb_sram_like_data_responder.sv
// Directed bench for sram_like_data_responder with hand-computed expectations.
module tb_sram_like_data_responder;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic [3:0]  cfg_latency;
   logic [2:0]  outstanding;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sram_like_data_responder #(
      .MEM_AW          (12),
      .MAX_OUTSTANDING (4),
      .LAT_W           (4)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req         (req),
      .wr          (wr),
      .size        (size),
      .wstrb       (wstrb),
      .addr        (addr),
      .wdata       (wdata),
      .addr_ok     (addr_ok),
      .data_ok     (data_ok),
      .rdata       (rdata),
      .cfg_latency (cfg_latency),
      .outstanding (outstanding)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [3:0] lat);
      req = r; wr = w; addr = a; wdata = d; wstrb = s; cfg_latency = lat;
      size = w ? 2'd2 : 2'd2;
   endtask

   task automatic idle();
      req = 1'b0; wr = 1'b0; wstrb = 4'h0;
   endtask

   initial begin
      int exp_out [19] = '{0,1,2,3,4,4,4,4,4,3,3,2,1,1,1,1,1,1,0};
      resetn = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'd0);

      // reset state
      step(); step();
      @(negedge clk);
      chk("rst_data_ok", 32'(data_ok), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_addr_ok", 32'(addr_ok), 32'd0);
      step();
      resetn = 1'b1;

      // lat 0: store then load
      drive(1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF, 4'd0);
      @(negedge clk);
      chk("l0_st_addr_ok", 32'(addr_ok), 32'd1);
      chk("l0_st_no_same_cycle_ok", 32'(data_ok), 32'd0);
      step();
      drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 4'd0);
      @(negedge clk);
      chk("l0_st_data_ok", 32'(data_ok), 32'd1);
      chk("l0_st_rdata", rdata, 32'd0);
      chk("l0_ld_addr_ok", 32'(addr_ok), 32'd1);
      step();
      idle();
      @(negedge clk);
      chk("l0_ld_data_ok", 32'(data_ok), 32'd1);
      chk("l0_ld_rdata", rdata, 32'h12345678);
      step();
      @(negedge clk);
      chk("l0_drained_ok", 32'(data_ok), 32'd0);
      chk("l0_drained_rdata", rdata, 32'd0);
      chk("l0_drained_out", 32'(outstanding), 32'd0);

      // byte merge
      step();
      drive(1'b1, 1'b1, 32'h102, 32'h0000AB00, 4'b0010, 4'd0);
      @(negedge clk);
      chk("bm_st_addr_ok", 32'(addr_ok), 32'd1);
      step();
      drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 4'd0);
      @(negedge clk);
      chk("bm_st_rdata", rdata, 32'd0);
      step();
      idle();
      @(negedge clk);
      chk("bm_ld_data_ok", 32'(data_ok), 32'd1);
      chk("bm_ld_rdata", rdata, 32'h1234AB78);

      // latency 3
      step();
      drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 4'd3);
      @(negedge clk);
      chk("lat3_addr_ok", 32'(addr_ok), 32'd1);
      chk("lat3_out_T", 32'(outstanding), 32'd0);
      step();
      idle();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("lat3_out_T+%0d", k), 32'(outstanding), 32'd1);
         chk($sformatf("lat3_data_ok_T+%0d", k), 32'(data_ok), (k == 4) ? 32'd1 : 32'd0);
         chk($sformatf("lat3_rdata_T+%0d", k), rdata, (k == 4) ? 32'h1234AB78 : 32'd0);
         step();
      end
      @(negedge clk);
      chk("lat3_out_T+5", 32'(outstanding), 32'd0);
      chk("lat3_data_ok_T+5", 32'(data_ok), 32'd0);

      // seed two words, including one through a wrapped address
      step();
      drive(1'b1, 1'b1, 32'h200, 32'hAAAA0001, 4'hF, 4'd0);
      step();
      drive(1'b1, 1'b1, 32'h0000_4204, 32'hBBBB0002, 4'hF, 4'd0);
      step();
      idle();
      step();
      step();

      // full: lat 7, five back-to-back loads
      drive(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 4'd7);
      for (int k = 0; k <= 18; k++) begin
         @(negedge clk);
         chk($sformatf("full_addr_ok_k%0d", k), 32'(addr_ok),
             (k <= 9 && (k < 4 || k == 9)) ? 32'd1 : 32'd0);
         chk($sformatf("full_data_ok_k%0d", k), 32'(data_ok),
             ((k >= 8 && k <= 11) || k == 17) ? 32'd1 : 32'd0);
         chk($sformatf("full_rdata_k%0d", k), rdata,
             ((k >= 8 && k <= 11) || k == 17) ? 32'hAAAA0001 : 32'd0);
         chk($sformatf("full_out_k%0d", k), 32'(outstanding), 32'(exp_out[k]));
         step();
         if (k == 9) idle();
      end

      // ordering: A lat 5 at T, B lat 0 at T+1
      drive(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 4'd5);
      @(negedge clk);
      chk("ord_A_addr_ok", 32'(addr_ok), 32'd1);
      step();
      drive(1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 4'd0);
      @(negedge clk);
      chk("ord_B_addr_ok", 32'(addr_ok), 32'd1);
      chk("ord_T+1_data_ok", 32'(data_ok), 32'd0);
      step();
      idle();
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("ord_data_ok_T+%0d", k), 32'(data_ok),
             (k == 6 || k == 7) ? 32'd1 : 32'd0);
         chk($sformatf("ord_rdata_T+%0d", k), rdata,
             (k == 6) ? 32'hAAAA0001 : (k == 7) ? 32'hBBBB0002 : 32'd0);
         step();
      end

      // reset with two loads in flight
      drive(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 4'd6);
      step();
      drive(1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 4'd6);
      step();
      idle();
      resetn = 1'b0;
      @(negedge clk);
      chk("rst2_out_before", 32'(outstanding), 32'd2);
      step();
      resetn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("rst2_data_ok_%0d", k), 32'(data_ok), 32'd0);
         chk($sformatf("rst2_out_%0d", k), 32'(outstanding), 32'd0);
         chk($sformatf("rst2_addr_ok_idle_%0d", k), 32'(addr_ok), 32'd0);
         step();
      end
      drive(1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 4'd0);
      @(negedge clk);
      chk("rst2_addr_ok_req", 32'(addr_ok), 32'd1);
      step();
      idle();
      @(negedge clk);
      chk("rst2_reload_ok", 32'(data_ok), 32'd1);
      chk("rst2_reload_rdata", rdata, 32'hBBBB0002);
      step();
      drive(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 4'd0);
      step();
      idle();
      @(negedge clk);
      chk("rst2_reload2_rdata", rdata, 32'h1234AB78);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
